// File: rtl/memory_access_stage.sv
// MEM pipeline stage: req/ack data-memory port with byte enables, load extension and timeout.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses without touching memory.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic        in_reg_write,
  input  logic [4:0]  in_dest_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_reg_write,
  output logic [4:0]  out_dest_reg,
  output logic        bus_error,
  output logic        misaligned
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_reg_write_q, out_reg_write_d;
  logic [4:0]  out_dest_reg_q, out_dest_reg_d;
  logic        bus_error_q, bus_error_d;
  logic        misaligned_q, misaligned_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] result_q, result_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  dest_q, dest_d;

  logic accept;
  logic is_mem;
  logic misal_in;

  assign accept = in_valid & (state_q == S_IDLE);
  assign is_mem = in_mem_read | in_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misal_in = is_mem & (((in_size == 2'b01) & in_result[0]) |
                              (in_size[1] & (|in_result[1:0])));
`else
  assign misal_in = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    out_valid_d     = 1'b0;
    out_data_d      = out_data_q;
    out_reg_write_d = 1'b0;
    out_dest_reg_d  = out_dest_reg_q;
    bus_error_d     = 1'b0;
    misaligned_d    = 1'b0;
    cnt_d           = cnt_q;
    is_load_d       = is_load_q;
    size_d          = size_q;
    uns_d           = uns_q;
    off_d           = off_q;
    result_d        = result_q;
    reg_write_d     = reg_write_q;
    dest_d          = dest_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem || misal_in) begin
            // Pass-through or rejected access completes one cycle after accept.
            out_valid_d     = 1'b1;
            out_data_d      = misal_in ? 32'h0 : in_result;
            out_reg_write_d = in_reg_write & ~misal_in;
            out_dest_reg_d  = in_dest_reg;
            misaligned_d    = misal_in;
          end else begin
            state_d     = S_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = in_mem_write;
            mem_addr_d  = {in_result[31:2], 2'b00};
            mem_be_d    = byte_en(in_size, in_result[1:0]);
            mem_wdata_d = store_lanes(in_size, in_store_data);
            cnt_d       = 8'd0;
            is_load_d   = in_mem_read;
            size_d      = in_size;
            uns_d       = in_unsigned;
            off_d       = in_result[1:0];
            result_d    = in_result;
            reg_write_d = in_reg_write;
            dest_d      = in_dest_reg;
          end
        end
      end
      S_ACCESS: begin
        // An ack on the timeout edge takes priority over the error.
        if (mem_ack || (cnt_q == 8'(TIMEOUT_CYCLES - 1))) begin
          state_d        = S_IDLE;
          mem_req_d      = 1'b0;
          mem_we_d       = 1'b0;
          cnt_d          = 8'd0;
          out_valid_d    = 1'b1;
          out_dest_reg_d = dest_q;
          if (mem_ack) begin
            out_data_d      = is_load_q ? load_extend(size_q, uns_q, off_q, mem_rdata) : result_q;
            out_reg_write_d = reg_write_q;
          end else begin
            out_data_d  = 32'h0;
            bus_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_wdata_q     <= 32'h0;
      mem_be_q        <= 4'h0;
      out_valid_q     <= 1'b0;
      out_data_q      <= 32'h0;
      out_reg_write_q <= 1'b0;
      out_dest_reg_q  <= 5'h0;
      bus_error_q     <= 1'b0;
      misaligned_q    <= 1'b0;
      cnt_q           <= 8'd0;
      is_load_q       <= 1'b0;
      size_q          <= 2'b00;
      uns_q           <= 1'b0;
      off_q           <= 2'b00;
      result_q        <= 32'h0;
      reg_write_q     <= 1'b0;
      dest_q          <= 5'h0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_reg_write_q <= out_reg_write_d;
      out_dest_reg_q  <= out_dest_reg_d;
      bus_error_q     <= bus_error_d;
      misaligned_q    <= misaligned_d;
      cnt_q           <= cnt_d;
      is_load_q       <= is_load_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      off_q           <= off_d;
      result_q        <= result_d;
      reg_write_q     <= reg_write_d;
      dest_q          <= dest_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_reg_write = out_reg_write_q;
  assign out_dest_reg  = out_dest_reg_q;
  assign bus_error     = bus_error_q;
  assign misaligned    = misaligned_q;

endmodule
